load_exec_unit: RTL and testbench
=================================

Name: load_exec_unit

Overview:
- Execution end of the load path in the Tomasulo core.
- Accepts one dispatched load from the load reservation station and computes the effective address.
- Performs a word read on the data-memory port, then extracts and extends the byte, halfword or word.
- Transmits the result on the common data bus (CDB) with a request/grant handshake, so the reservation stations and ROB can capture it.

Parameters:
- ROB_W, 6, width of ROB tag fields.
- DATA_W, 32, width of data, address and offset fields.
- INVALID_ROB, 6'b010000, tag driven on cdbRobNum when no broadcast is active.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dispatchValid  in  1  load presented by the load RS this cycle.
- dispatchRobNum  in  ROB_W  destination ROB tag.
- dispatchBase  in  DATA_W  resolved base register value.
- dispatchOffset  in  DATA_W  sign-extended immediate.
- dispatchSubType  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- dispatchReady  out  1  unit idle; a dispatch is accepted this cycle.
- flush  in  1  synchronous; discard the in-flight load.
- memReq  out  1  read request to data memory.
- memAddr  out  DATA_W  word-aligned address ({ea[31:2],2'b00}).
- memAck  in  1  memRdata valid; sampled only while memReq=1.
- memRdata  in  DATA_W  read word, little-endian.
- cdbReq  out  1  broadcast request; equals cdbIscast.
- cdbGrant  in  1  arbiter grants this unit the CDB this cycle.
- cdbIscast  out  1  broadcast valid.
- cdbRobNum  out  ROB_W  tag being broadcast.
- cdbData  out  DATA_W  loaded, extended value.
- cdbMisalign  out  1  broadcast carries a misaligned-access fault; cdbData=0.

Behaviour:
- Reset (async, any state): state=IDLE, dispatchReady=1, memReq=0, memAddr=0, cdbIscast=0, cdbRobNum=INVALID_ROB, cdbData=0, cdbMisalign=0. All latched fields cleared.
- States: IDLE, MEM, WAIT_DROP, BCAST.
- IDLE, dispatchValid=1:
  - Latch tag and subtype; ea = base + offset (mod 2^32, carry dropped).
  - Misaligned (LH/LHU with ea[0]=1, or LW with ea[1:0]!=0): go to BCAST with cdbMisalign=1, cdbData=0; no memory access.
  - Otherwise go to MEM: memReq=1, memAddr word-aligned, both registered, visible the cycle after dispatch.
  - dispatchReady=0 from that edge.
  - Undefined subtypes (011,110,111) are treated as LW.
- MEM: hold memReq and memAddr stable until memAck=1. On the ack edge: memReq=0, extract and extend (below) into cdbData, cdbIscast=1, cdbRobNum=tag, go to BCAST.
- Extraction:
  - byte = memRdata[8*ea[1:0] +: 8].
  - half = memRdata[16*ea[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- BCAST: hold cdbIscast, cdbRobNum, cdbData, cdbMisalign stable until cdbGrant=1. On the grant edge: cdbIscast=0, cdbRobNum=INVALID_ROB, cdbData=0, cdbMisalign=0, state=IDLE, dispatchReady=1.
- Minimum dispatch-to-broadcast latency: 2 cycles (dispatch, ack in first MEM cycle, grant in first BCAST cycle); back-to-back loads every 3 cycles.
- flush in IDLE: no effect; a simultaneous dispatchValid is ignored.
- flush in BCAST: drop the broadcast to the reset values, go to IDLE; flush beats a same-cycle cdbGrant.
- flush in MEM with memAck=0: go to WAIT_DROP; keep memReq asserted until memAck, then memReq=0 and go to IDLE with no broadcast.
- flush in MEM with memAck=1 the same cycle: go directly to IDLE, no broadcast.
- flush in WAIT_DROP: no additional effect.
- memAck or cdbGrant outside its owning state is ignored.
- Reset mid-operation abandons any outstanding memory request; the memory side must tolerate the dropped request.

Test Plan:
- LW aligned: base=0x100, off=0x4, ack 3 cycles later with 0xDEADBEEF, grant immediate -> memAddr=0x104; cdbIscast for 1 cycle with tag=5, data=0xDEADBEEF; dispatchReady high the following cycle.
- LB / LBU at ea=0x103, rdata=0x80123456 -> LB data=0xFFFFFF80; LBU data=0x00000080; LH at ea=0x102 -> 0xFFFF8012.
- Misaligned LW at ea=0x102 -> memReq never asserts; cdbMisalign=1, data=0, tag broadcast; held 4 cycles with grant low, then cleared on grant.
- Negative offset wrap: base=0x00000002, off=0xFFFFFFFE, LW -> memAddr=0x00000000, normal completion.
- flush while MEM with ack 2 cycles later -> memReq held until ack; no cdbIscast; dispatchReady=1 the cycle after ack. flush coincident with grant in BCAST -> broadcast dropped.
- Async reset asserted mid-BCAST between clock edges -> cdbIscast=0, cdbRobNum=0x10, dispatchReady=1 immediately, without waiting for an edge.

Source files
------------

// File: rtl/load_exec_unit.sv
// Load execution unit: effective-address generation, data-memory word read,
// byte/half/word extraction and CDB broadcast with request/grant handshake.
module load_exec_unit #(
    parameter int unsigned      ROB_W       = 6,
    parameter int unsigned      DATA_W      = 32,
    parameter logic [ROB_W-1:0] INVALID_ROB = ROB_W'(16)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_dispatch_valid,
    input  logic [ROB_W-1:0]  i_dispatch_rob_num,
    input  logic [DATA_W-1:0] i_dispatch_base,
    input  logic [DATA_W-1:0] i_dispatch_offset,
    input  logic [2:0]        i_dispatch_sub_type,
    output logic              o_dispatch_ready,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic [DATA_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cdb_req,
    input  logic              i_cdb_grant,
    output logic              o_cdb_iscast,
    output logic [ROB_W-1:0]  o_cdb_rob_num,
    output logic [DATA_W-1:0] o_cdb_data,
    output logic              o_cdb_misalign
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMem      = 2'd1,
        StWaitDrop = 2'd2,
        StBcast    = 2'd3
    } state_e;

    localparam logic [2:0] SubLb  = 3'b000;
    localparam logic [2:0] SubLh  = 3'b001;
    localparam logic [2:0] SubLbu = 3'b100;
    localparam logic [2:0] SubLhu = 3'b101;

    state_e             r_state, w_state_d;
    logic [ROB_W-1:0]   r_tag, w_tag_d;
    logic [2:0]         r_sub, w_sub_d;
    logic [1:0]         r_ea_lo, w_ea_lo_d;
    logic               r_mem_req, w_mem_req_d;
    logic [DATA_W-1:0]  r_mem_addr, w_mem_addr_d;
    logic               r_cdb_valid, w_cdb_valid_d;
    logic [ROB_W-1:0]   r_cdb_rob, w_cdb_rob_d;
    logic [DATA_W-1:0]  r_cdb_data, w_cdb_data_d;
    logic               r_cdb_mis, w_cdb_mis_d;

    logic [DATA_W-1:0]  w_ea;
    logic               w_is_byte;
    logic               w_is_half;
    logic               w_misalign;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [DATA_W-1:0]  w_load;

    assign w_ea      = i_dispatch_base + i_dispatch_offset;
    assign w_is_byte = (i_dispatch_sub_type == SubLb) || (i_dispatch_sub_type == SubLbu);
    assign w_is_half = (i_dispatch_sub_type == SubLh) || (i_dispatch_sub_type == SubLhu);
    // Anything that is neither byte nor half (incl. undefined funct3) behaves as LW.
    assign w_misalign = (w_is_half && w_ea[0]) ||
                        (!w_is_byte && !w_is_half && (w_ea[1:0] != 2'b00));

    always_comb begin
        w_byte = i_mem_rdata[{r_ea_lo, 3'b000} +: 8];
        w_half = i_mem_rdata[{r_ea_lo[1], 4'b0000} +: 16];
        unique case (r_sub)
            SubLb:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
            SubLbu:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
            SubLh:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
            SubLhu:  w_load = {{(DATA_W-16){1'b0}}, w_half};
            default: w_load = i_mem_rdata;
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        w_tag_d       = r_tag;
        w_sub_d       = r_sub;
        w_ea_lo_d     = r_ea_lo;
        w_mem_req_d   = r_mem_req;
        w_mem_addr_d  = r_mem_addr;
        w_cdb_valid_d = r_cdb_valid;
        w_cdb_rob_d   = r_cdb_rob;
        w_cdb_data_d  = r_cdb_data;
        w_cdb_mis_d   = r_cdb_mis;

        unique case (r_state)
            StIdle: begin
                if (i_dispatch_valid && !i_flush) begin
                    w_tag_d   = i_dispatch_rob_num;
                    w_sub_d   = i_dispatch_sub_type;
                    w_ea_lo_d = w_ea[1:0];
                    if (w_misalign) begin
                        w_state_d     = StBcast;
                        w_cdb_valid_d = 1'b1;
                        w_cdb_rob_d   = i_dispatch_rob_num;
                        w_cdb_data_d  = '0;
                        w_cdb_mis_d   = 1'b1;
                    end else begin
                        w_state_d    = StMem;
                        w_mem_req_d  = 1'b1;
                        w_mem_addr_d = {w_ea[DATA_W-1:2], 2'b00};
                    end
                end
            end
            StMem: begin
                if (i_mem_ack) begin
                    w_mem_req_d = 1'b0;
                    if (i_flush) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d     = StBcast;
                        w_cdb_valid_d = 1'b1;
                        w_cdb_rob_d   = r_tag;
                        w_cdb_data_d  = w_load;
                        w_cdb_mis_d   = 1'b0;
                    end
                end else if (i_flush) begin
                    w_state_d = StWaitDrop;
                end
            end
            StWaitDrop: begin
                // Request stays up until memory answers; the data is discarded.
                if (i_mem_ack) begin
                    w_mem_req_d = 1'b0;
                    w_state_d   = StIdle;
                end
            end
            StBcast: begin
                if (i_flush || i_cdb_grant) begin
                    w_state_d     = StIdle;
                    w_cdb_valid_d = 1'b0;
                    w_cdb_rob_d   = INVALID_ROB;
                    w_cdb_data_d  = '0;
                    w_cdb_mis_d   = 1'b0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_tag       <= '0;
            r_sub       <= '0;
            r_ea_lo     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_rob   <= INVALID_ROB;
            r_cdb_data  <= '0;
            r_cdb_mis   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_tag       <= w_tag_d;
            r_sub       <= w_sub_d;
            r_ea_lo     <= w_ea_lo_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_addr  <= w_mem_addr_d;
            r_cdb_valid <= w_cdb_valid_d;
            r_cdb_rob   <= w_cdb_rob_d;
            r_cdb_data  <= w_cdb_data_d;
            r_cdb_mis   <= w_cdb_mis_d;
        end
    end

    assign o_dispatch_ready = (r_state == StIdle);
    assign o_mem_req        = r_mem_req;
    assign o_mem_addr       = r_mem_addr;
    assign o_cdb_req        = r_cdb_valid;
    assign o_cdb_iscast     = r_cdb_valid;
    assign o_cdb_rob_num    = r_cdb_rob;
    assign o_cdb_data       = r_cdb_data;
    assign o_cdb_misalign   = r_cdb_mis;

endmodule

// File: tb/tb_load_exec_unit.sv
// Directed self-checking bench for load_exec_unit: one task per scenario,
// expected values hand-computed from the load semantics.
module tb_load_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic [5:0]  dispatch_rob_num;
    logic [31:0] dispatch_base;
    logic [31:0] dispatch_offset;
    logic [2:0]  dispatch_sub_type;
    logic        dispatch_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        cdb_req;
    logic        cdb_grant;
    logic        cdb_iscast;
    logic [5:0]  cdb_rob_num;
    logic [31:0] cdb_data;
    logic        cdb_misalign;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    load_exec_unit dut (
        .i_clock             (clock),
        .i_reset             (reset),
        .i_dispatch_valid    (dispatch_valid),
        .i_dispatch_rob_num  (dispatch_rob_num),
        .i_dispatch_base     (dispatch_base),
        .i_dispatch_offset   (dispatch_offset),
        .i_dispatch_sub_type (dispatch_sub_type),
        .o_dispatch_ready    (dispatch_ready),
        .i_flush             (flush),
        .o_mem_req           (mem_req),
        .o_mem_addr          (mem_addr),
        .i_mem_ack           (mem_ack),
        .i_mem_rdata         (mem_rdata),
        .o_cdb_req           (cdb_req),
        .i_cdb_grant         (cdb_grant),
        .o_cdb_iscast        (cdb_iscast),
        .o_cdb_rob_num       (cdb_rob_num),
        .o_cdb_data          (cdb_data),
        .o_cdb_misalign      (cdb_misalign)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] tag, input logic [31:0] base,
                            input logic [31:0] off, input logic [2:0] sub);
        n_cmp++;
        if (dispatch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dispatch_ready_before_dispatch: got %b want 1", dispatch_ready);
        end
        dispatch_valid    = 1'b1;
        dispatch_rob_num  = tag;
        dispatch_base     = base;
        dispatch_offset   = off;
        dispatch_sub_type = sub;
        tick();
        dispatch_valid = 1'b0;
    endtask

    // Full normal load: dispatch, ack after ack_wait extra MEM cycles, immediate grant.
    task automatic do_load(input string name, input logic [5:0] tag, input logic [31:0] base,
                           input logic [31:0] off, input logic [2:0] sub,
                           input logic [31:0] rdata, input int ack_wait,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        dispatch(tag, base, off, sub);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || dispatch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_mem: got req=%b addr=%h rdy=%b want req=1 addr=%h rdy=0",
                     name, mem_req, mem_addr, dispatch_ready, exp_addr);
        end
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || cdb_iscast !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_mem_hold: got req=%b addr=%h cast=%b want req=1 addr=%h cast=0",
                         name, mem_req, mem_addr, cdb_iscast, exp_addr);
            end
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        n_cmp++;
        if (mem_req !== 1'b0 || cdb_iscast !== 1'b1 || cdb_req !== 1'b1 ||
            cdb_rob_num !== tag || cdb_data !== exp_data || cdb_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_bcast: got req=%b cast=%b creq=%b tag=%h data=%h mis=%b want 0 1 1 %h %h 0",
                     name, mem_req, cdb_iscast, cdb_req, cdb_rob_num, cdb_data, cdb_misalign,
                     tag, exp_data);
        end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        n_cmp++;
        if (cdb_iscast !== 1'b0 || cdb_rob_num !== 6'h10 || cdb_data !== 32'h0 ||
            dispatch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: got cast=%b tag=%h data=%h rdy=%b want 0 10 0 1",
                     name, cdb_iscast, cdb_rob_num, cdb_data, dispatch_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (dispatch_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h0 ||
            cdb_iscast !== 1'b0 || cdb_rob_num !== 6'h10 || cdb_data !== 32'h0 ||
            cdb_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b req=%b addr=%h cast=%b tag=%h data=%h mis=%b",
                     dispatch_ready, mem_req, mem_addr, cdb_iscast, cdb_rob_num, cdb_data,
                     cdb_misalign);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lw_aligned();
        do_load("lw", 6'd5, 32'h100, 32'h4, 3'b010, 32'hDEADBEEF, 2, 32'h104, 32'hDEADBEEF);
    endtask

    task automatic test_extract();
        do_load("lb",  6'd1, 32'h100, 32'h3, 3'b000, 32'h80123456, 0, 32'h100, 32'hFFFFFF80);
        do_load("lbu", 6'd2, 32'h100, 32'h3, 3'b100, 32'h80123456, 0, 32'h100, 32'h00000080);
        do_load("lh",  6'd3, 32'h100, 32'h2, 3'b001, 32'h80123456, 1, 32'h100, 32'hFFFF8012);
        do_load("lhu", 6'd4, 32'h100, 32'h2, 3'b101, 32'h80123456, 0, 32'h100, 32'h00008012);
        do_load("lb0", 6'd6, 32'h0FF, 32'h1, 3'b000, 32'h80123456, 0, 32'h100, 32'h00000056);
        do_load("lh0", 6'd7, 32'h100, 32'h0, 3'b001, 32'h0000F234, 0, 32'h100, 32'hFFFFF234);
        do_load("undef", 6'd8, 32'h200, 32'h0, 3'b111, 32'hCAFE0001, 0, 32'h200, 32'hCAFE0001);
    endtask

    task automatic test_misaligned();
        dispatch(6'd9, 32'h100, 32'h2, 3'b010);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem_req !== 1'b0 || cdb_iscast !== 1'b1 || cdb_misalign !== 1'b1 ||
                cdb_data !== 32'h0 || cdb_rob_num !== 6'd9 || dispatch_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_hold%0d: got req=%b cast=%b mis=%b data=%h tag=%h rdy=%b",
                         i, mem_req, cdb_iscast, cdb_misalign, cdb_data, cdb_rob_num,
                         dispatch_ready);
            end
            tick();
        end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        n_cmp++;
        if (cdb_iscast !== 1'b0 || cdb_misalign !== 1'b0 || cdb_rob_num !== 6'h10 ||
            dispatch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_clear: got cast=%b mis=%b tag=%h rdy=%b want 0 0 10 1",
                     cdb_iscast, cdb_misalign, cdb_rob_num, dispatch_ready);
        end
        dispatch(6'd11, 32'h101, 32'h0, 3'b101);
        n_cmp++;
        if (mem_req !== 1'b0 || cdb_misalign !== 1'b1 || cdb_rob_num !== 6'd11) begin
            n_fail++;
            $display("FAIL misalign_lhu: got req=%b mis=%b tag=%h want 0 1 0b",
                     mem_req, cdb_misalign, cdb_rob_num);
        end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
    endtask

    task automatic test_wrap();
        do_load("wrap", 6'd12, 32'h2, 32'hFFFFFFFE, 3'b010, 32'h12345678, 0, 32'h0, 32'h12345678);
    endtask

    task automatic test_flush();
        // Flush in MEM, ack arrives two cycles later.
        dispatch(6'd3, 32'h200, 32'h0, 3'b010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b1 || dispatch_ready !== 1'b0 || cdb_iscast !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mem_hold: got req=%b rdy=%b cast=%b want 1 0 0",
                     mem_req, dispatch_ready, cdb_iscast);
        end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0 || cdb_iscast !== 1'b0 || dispatch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_mem_drop: got req=%b cast=%b rdy=%b want 0 0 1",
                     mem_req, cdb_iscast, dispatch_ready);
        end
        // Flush coincident with ack.
        dispatch(6'd4, 32'h200, 32'h0, 3'b010);
        flush   = 1'b1;
        mem_ack = 1'b1;
        tick();
        flush   = 1'b0;
        mem_ack = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0 || cdb_iscast !== 1'b0 || dispatch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ack_same: got req=%b cast=%b rdy=%b want 0 0 1",
                     mem_req, cdb_iscast, dispatch_ready);
        end
        // Flush alone in BCAST, then flush coincident with grant.
        for (int k = 0; k < 2; k++) begin
            dispatch(6'd13, 32'h100, 32'h1, 3'b010);
            flush     = 1'b1;
            cdb_grant = (k == 1);
            tick();
            flush     = 1'b0;
            cdb_grant = 1'b0;
            n_cmp++;
            if (cdb_iscast !== 1'b0 || cdb_rob_num !== 6'h10 || cdb_misalign !== 1'b0 ||
                dispatch_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_bcast%0d: got cast=%b tag=%h mis=%b rdy=%b want 0 10 0 1",
                         k, cdb_iscast, cdb_rob_num, cdb_misalign, dispatch_ready);
            end
        end
    endtask

    task automatic test_idle_ignores();
        flush     = 1'b1;
        mem_ack   = 1'b1;
        cdb_grant = 1'b1;
        dispatch(6'd14, 32'h300, 32'h0, 3'b010);
        flush     = 1'b0;
        mem_ack   = 1'b0;
        cdb_grant = 1'b0;
        n_cmp++;
        if (dispatch_ready !== 1'b1 || mem_req !== 1'b0 || cdb_iscast !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_flush: got rdy=%b req=%b cast=%b want 1 0 0",
                     dispatch_ready, mem_req, cdb_iscast);
        end
    endtask

    task automatic test_back_to_back();
        do_load("b2b_a", 6'd20, 32'h400, 32'h8, 3'b010, 32'h11112222, 0, 32'h408, 32'h11112222);
        do_load("b2b_b", 6'd21, 32'h400, 32'hC, 3'b001, 32'h00009ABC, 0, 32'h40C, 32'hFFFF9ABC);
    endtask

    task automatic test_async_reset();
        dispatch(6'd30, 32'h500, 32'h0, 3'b010);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA55AA;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (cdb_iscast !== 1'b1 || cdb_rob_num !== 6'd30) begin
            n_fail++;
            $display("FAIL areset_pre: got cast=%b tag=%h want 1 1e", cdb_iscast, cdb_rob_num);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (cdb_iscast !== 1'b0 || cdb_rob_num !== 6'h10 || cdb_data !== 32'h0 ||
            dispatch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_now: got cast=%b tag=%h data=%h rdy=%b want 0 10 0 1",
                     cdb_iscast, cdb_rob_num, cdb_data, dispatch_ready);
        end
        #2;
        reset = 1'b0;
        tick();
        do_load("post_reset", 6'd31, 32'h600, 32'h1, 3'b100, 32'h0000EE00, 0, 32'h600,
                32'h000000EE);
    endtask

    initial begin
        reset             = 1'b1;
        dispatch_valid    = 1'b0;
        dispatch_rob_num  = '0;
        dispatch_base     = '0;
        dispatch_offset   = '0;
        dispatch_sub_type = '0;
        flush             = 1'b0;
        mem_ack           = 1'b0;
        mem_rdata         = '0;
        cdb_grant         = 1'b0;
        #1;
        test_reset();
        test_lw_aligned();
        test_extract();
        test_misaligned();
        test_wrap();
        test_flush();
        test_idle_ignores();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
